// File: rtl/lbp_qtr_assembler_if.sv
// Narrow-bus pins from the LBP chip plus the reassembled full-width words.
// The slave side is the assembler; the master side is whatever drives the pads.
interface lbp_qtr_assembler_if;
    logic        gray_qtr_valid;
    logic [3:0]  gray_addr_qtr;
    logic        lbp_qtr_valid;
    logic [3:0]  lbp_addr_qtr;
    logic [1:0]  lbp_data_qtr;
    logic [13:0] gray_addr;
    logic        gray_req;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        lbp_valid;
    logic [1:0]  gray_count;
    logic [1:0]  lbp_count;
    logic        frame_err;

    modport master (
        output gray_qtr_valid, gray_addr_qtr, lbp_qtr_valid, lbp_addr_qtr, lbp_data_qtr,
        input  gray_addr, gray_req, lbp_addr, lbp_data, lbp_valid,
        input  gray_count, lbp_count, frame_err
    );

    modport slave (
        input  gray_qtr_valid, gray_addr_qtr, lbp_qtr_valid, lbp_addr_qtr, lbp_data_qtr,
        output gray_addr, gray_req, lbp_addr, lbp_data, lbp_valid,
        output gray_count, lbp_count, frame_err
    );
endinterface

// File: rtl/lbp_qtr_assembler.sv
// Reassembles 4-beat MSB-first quarter transfers into 14-bit addresses and 8-bit
// LBP data; gray and LBP channels run independently, each tracked by its beat counter.
module lbp_qtr_assembler (
    input  logic                clk,
    input  logic                reset_n,
    lbp_qtr_assembler_if.slave  bus
);
    logic [1:0]  gray_cnt_q, gray_cnt_d;
    logic [9:0]  gray_acc_q, gray_acc_d;
    logic [13:0] gray_addr_q, gray_addr_d;
    logic        gray_req_q, gray_req_d;
    logic        gray_abort;

    logic [1:0]  lbp_cnt_q, lbp_cnt_d;
    logic [9:0]  lbp_acc_q, lbp_acc_d;
    logic [5:0]  lbp_dacc_q, lbp_dacc_d;
    logic [13:0] lbp_addr_q, lbp_addr_d;
    logic [7:0]  lbp_data_q, lbp_data_d;
    logic        lbp_valid_q, lbp_valid_d;
    logic        lbp_abort;

    logic        frame_err_q, frame_err_d;

    // Beat 0 restarts the accumulator, so only qtr[1:0] of that beat survives.
    always_comb begin
        gray_cnt_d  = gray_cnt_q;
        gray_acc_d  = gray_acc_q;
        gray_addr_d = gray_addr_q;
        gray_req_d  = 1'b0;
        gray_abort  = 1'b0;
        if (bus.gray_qtr_valid) begin
            if (gray_cnt_q == 2'd3) begin
                gray_addr_d = {gray_acc_q, bus.gray_addr_qtr};
                gray_req_d  = 1'b1;
                gray_cnt_d  = 2'd0;
                gray_acc_d  = '0;
            end else begin
                gray_cnt_d = gray_cnt_q + 2'd1;
                gray_acc_d = (gray_cnt_q == 2'd0) ? {8'd0, bus.gray_addr_qtr[1:0]}
                                                  : {gray_acc_q[5:0], bus.gray_addr_qtr};
            end
        end else if (gray_cnt_q != 2'd0) begin
            gray_abort = 1'b1;
            gray_cnt_d = 2'd0;
            gray_acc_d = '0;
        end
    end

    always_comb begin
        lbp_cnt_d   = lbp_cnt_q;
        lbp_acc_d   = lbp_acc_q;
        lbp_dacc_d  = lbp_dacc_q;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;
        lbp_valid_d = 1'b0;
        lbp_abort   = 1'b0;
        if (bus.lbp_qtr_valid) begin
            if (lbp_cnt_q == 2'd3) begin
                lbp_addr_d  = {lbp_acc_q, bus.lbp_addr_qtr};
                lbp_data_d  = {lbp_dacc_q, bus.lbp_data_qtr};
                lbp_valid_d = 1'b1;
                lbp_cnt_d   = 2'd0;
                lbp_acc_d   = '0;
                lbp_dacc_d  = '0;
            end else begin
                lbp_cnt_d = lbp_cnt_q + 2'd1;
                if (lbp_cnt_q == 2'd0) begin
                    lbp_acc_d  = {8'd0, bus.lbp_addr_qtr[1:0]};
                    lbp_dacc_d = {4'd0, bus.lbp_data_qtr};
                end else begin
                    lbp_acc_d  = {lbp_acc_q[5:0], bus.lbp_addr_qtr};
                    lbp_dacc_d = {lbp_dacc_q[3:0], bus.lbp_data_qtr};
                end
            end
        end else if (lbp_cnt_q != 2'd0) begin
            lbp_abort  = 1'b1;
            lbp_cnt_d  = 2'd0;
            lbp_acc_d  = '0;
            lbp_dacc_d = '0;
        end
    end

    assign frame_err_d = gray_abort | lbp_abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gray_cnt_q  <= '0;
            gray_acc_q  <= '0;
            gray_addr_q <= '0;
            gray_req_q  <= 1'b0;
            lbp_cnt_q   <= '0;
            lbp_acc_q   <= '0;
            lbp_dacc_q  <= '0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            lbp_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            gray_cnt_q  <= gray_cnt_d;
            gray_acc_q  <= gray_acc_d;
            gray_addr_q <= gray_addr_d;
            gray_req_q  <= gray_req_d;
            lbp_cnt_q   <= lbp_cnt_d;
            lbp_acc_q   <= lbp_acc_d;
            lbp_dacc_q  <= lbp_dacc_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
            lbp_valid_q <= lbp_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.gray_addr  = gray_addr_q;
    assign bus.gray_req   = gray_req_q;
    assign bus.lbp_addr   = lbp_addr_q;
    assign bus.lbp_data   = lbp_data_q;
    assign bus.lbp_valid  = lbp_valid_q;
    assign bus.gray_count = gray_cnt_q;
    assign bus.lbp_count  = lbp_cnt_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_lbp_qtr_assembler.sv
// Bench for lbp_qtr_assembler: fixed frame table, hand-written abort/reset sequences,
// and a random beat stream checked every cycle against a queue-based frame model.
module tb_lbp_qtr_assembler;
    logic clk;
    logic reset_n;
    lbp_qtr_assembler_if bus ();

    lbp_qtr_assembler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: beats collected per channel, word built arithmetically.
    int gq[$];
    int laq[$];
    int ldq[$];
    int e_gaddr, e_greq, e_laddr, e_ldata, e_lvalid, e_ferr;

    typedef struct {
        logic [15:0] g;
        logic [15:0] la;
        logic [7:0]  ld;
        logic [13:0] exp_g;
        logic [13:0] exp_la;
        logic [7:0]  exp_ld;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        gq.delete(); laq.delete(); ldq.delete();
        e_gaddr = 0; e_greq = 0; e_laddr = 0; e_ldata = 0; e_lvalid = 0; e_ferr = 0;
    endtask

    task automatic model_edge(input logic gv, input logic [3:0] ga, input logic lv,
                              input logic [3:0] la, input logic [1:0] ld);
        int ab;
        ab = 0; e_greq = 0; e_lvalid = 0;
        if (gv) begin
            if (gq.size() == 3) begin
                e_gaddr = (gq[0] % 4) * 4096 + gq[1] * 256 + gq[2] * 16 + int'(ga);
                e_greq = 1;
                gq.delete();
            end else gq.push_back(int'(ga));
        end else if (gq.size() != 0) begin
            ab = 1; gq.delete();
        end
        if (lv) begin
            if (laq.size() == 3) begin
                e_laddr = (laq[0] % 4) * 4096 + laq[1] * 256 + laq[2] * 16 + int'(la);
                e_ldata = ldq[0] * 64 + ldq[1] * 16 + ldq[2] * 4 + int'(ld);
                e_lvalid = 1;
                laq.delete(); ldq.delete();
            end else begin
                laq.push_back(int'(la)); ldq.push_back(int'(ld));
            end
        end else if (laq.size() != 0) begin
            ab = 1; laq.delete(); ldq.delete();
        end
        e_ferr = ab;
    endtask

    task automatic check_model();
        chk("gray_addr",  int'(bus.gray_addr),  e_gaddr);
        chk("gray_req",   int'(bus.gray_req),   e_greq);
        chk("lbp_addr",   int'(bus.lbp_addr),   e_laddr);
        chk("lbp_data",   int'(bus.lbp_data),   e_ldata);
        chk("lbp_valid",  int'(bus.lbp_valid),  e_lvalid);
        chk("gray_count", int'(bus.gray_count), gq.size());
        chk("lbp_count",  int'(bus.lbp_count),  laq.size());
        chk("frame_err",  int'(bus.frame_err),  e_ferr);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " gray_addr"},  int'(bus.gray_addr),  0);
        chk({tag, " gray_req"},   int'(bus.gray_req),   0);
        chk({tag, " lbp_addr"},   int'(bus.lbp_addr),   0);
        chk({tag, " lbp_data"},   int'(bus.lbp_data),   0);
        chk({tag, " lbp_valid"},  int'(bus.lbp_valid),  0);
        chk({tag, " gray_count"}, int'(bus.gray_count), 0);
        chk({tag, " lbp_count"},  int'(bus.lbp_count),  0);
        chk({tag, " frame_err"},  int'(bus.frame_err),  0);
    endtask

    // Drive one cycle of beats, clock it in, then compare against the model.
    task automatic step(input logic gv, input logic [3:0] ga, input logic lv,
                        input logic [3:0] la, input logic [1:0] ld);
        bus.gray_qtr_valid = gv;
        bus.gray_addr_qtr  = ga;
        bus.lbp_qtr_valid  = lv;
        bus.lbp_addr_qtr   = la;
        bus.lbp_data_qtr   = ld;
        @(posedge clk);
        model_edge(gv, ga, lv, la, ld);
        #1;
        check_model();
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 1'b0, 4'h0, 2'd0);
    endtask

    initial begin
        vecs[0] = '{16'h2A5C, 16'h3FFF, 8'b10_11_01_00, 14'h2A5C, 14'h3FFF, 8'hB4};
        vecs[1] = '{16'h0001, 16'h1234, 8'b00_01_10_11, 14'h0001, 14'h1234, 8'h1B};
        vecs[2] = '{16'hE123, 16'hC000, 8'hFF,          14'h2123, 14'h0000, 8'hFF};
        vecs[3] = '{16'h7FFF, 16'h5A5A, 8'h5A,          14'h3FFF, 14'h1A5A, 8'h5A};

        reset_n = 1'b1;
        bus.gray_qtr_valid = 1'b0; bus.gray_addr_qtr = '0;
        bus.lbp_qtr_valid  = 1'b0; bus.lbp_addr_qtr  = '0; bus.lbp_data_qtr = '0;
        #2 reset_n = 1'b0;
        #1 check_zero("reset");
        @(posedge clk); @(posedge clk);
        #3 reset_n = 1'b1;
        model_clear();

        // Table frames, both channels together, back-to-back with no idle gap.
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 4; b++) begin
                chk("tbl gray_count", int'(bus.gray_count), b);
                chk("tbl lbp_count",  int'(bus.lbp_count),  b);
                step(1'b1, vecs[i].g[15-4*b -: 4], 1'b1, vecs[i].la[15-4*b -: 4],
                     vecs[i].ld[7-2*b -: 2]);
            end
            chk("tbl gray_addr", int'(bus.gray_addr), int'(vecs[i].exp_g));
            chk("tbl gray_req",  int'(bus.gray_req),  1);
            chk("tbl lbp_addr",  int'(bus.lbp_addr),  int'(vecs[i].exp_la));
            chk("tbl lbp_data",  int'(bus.lbp_data),  int'(vecs[i].exp_ld));
            chk("tbl lbp_valid", int'(bus.lbp_valid), 1);
            $display("vector %0d: gray_addr=%h lbp_addr=%h lbp_data=%h", i,
                     bus.gray_addr, bus.lbp_addr, bus.lbp_data);
        end
        idle();
        chk("pulse width gray_req", int'(bus.gray_req), 0);
        chk("pulse width lbp_valid", int'(bus.lbp_valid), 0);

        // LBP abort after two beats, then a clean frame.
        step(1'b0, 4'h0, 1'b1, 4'h9, 2'd1);
        step(1'b0, 4'h0, 1'b1, 4'h9, 2'd1);
        idle();
        chk("abort frame_err", int'(bus.frame_err), 1);
        chk("abort lbp_valid", int'(bus.lbp_valid), 0);
        chk("abort lbp_addr",  int'(bus.lbp_addr),  14'h1A5A);
        chk("abort lbp_data",  int'(bus.lbp_data),  8'h5A);
        idle();
        chk("abort frame_err width", int'(bus.frame_err), 0);
        step(1'b0, 4'h0, 1'b1, 4'h1, 2'd0);
        step(1'b0, 4'h0, 1'b1, 4'h2, 2'd1);
        step(1'b0, 4'h0, 1'b1, 4'h3, 2'd2);
        step(1'b0, 4'h0, 1'b1, 4'h4, 2'd3);
        chk("post-abort lbp_addr", int'(bus.lbp_addr), 14'h1234);
        chk("post-abort lbp_data", int'(bus.lbp_data), 8'h1B);
        $display("abort sequence: lbp_addr=%h lbp_data=%h", bus.lbp_addr, bus.lbp_data);

        // Both channels abort on the same edge: a single frame_err pulse.
        step(1'b1, 4'h1, 1'b1, 4'h1, 2'd1);
        step(1'b0, 4'h0, 1'b1, 4'h1, 2'd1);
        step(1'b0, 4'h0, 1'b1, 4'h1, 2'd1);
        // gray aborted on the previous edge; finish lbp abort next
        idle();
        chk("dual frame_err", int'(bus.frame_err), 1);
        step(1'b1, 4'h2, 1'b1, 4'h2, 2'd2);
        idle();
        chk("simul abort frame_err", int'(bus.frame_err), 1);
        idle();
        chk("simul abort width", int'(bus.frame_err), 0);
        $display("simultaneous abort sequence done");

        // Asynchronous reset between edges after gray beat 2.
        step(1'b1, 4'h3, 1'b0, 4'h0, 2'd0);
        step(1'b1, 4'hF, 1'b0, 4'h0, 2'd0);
        step(1'b1, 4'hF, 1'b0, 4'h0, 2'd0);
        #4 reset_n = 1'b0;
        #1 check_zero("midreset");
        #2 reset_n = 1'b1;
        model_clear();
        idle();
        step(1'b1, 4'h1, 1'b0, 4'h0, 2'd0);
        step(1'b1, 4'h2, 1'b0, 4'h0, 2'd0);
        step(1'b1, 4'h3, 1'b0, 4'h0, 2'd0);
        step(1'b1, 4'h4, 1'b0, 4'h0, 2'd0);
        chk("post-reset gray_addr", int'(bus.gray_addr), 14'h1234);
        chk("post-reset gray_req",  int'(bus.gray_req),  1);
        $display("reset mid-frame: gray_addr=%h", bus.gray_addr);

        // Random beat stream against the model.
        for (int c = 0; c < 400; c++) begin
            logic gv, lv;
            gv = ($urandom_range(0, 9) != 0);
            lv = ($urandom_range(0, 9) != 0);
            step(gv, 4'($urandom), lv, 4'($urandom), 2'($urandom));
            if (e_greq != 0) $display("rand gray word %h", e_gaddr[13:0]);
            if (e_lvalid != 0) $display("rand lbp word %h data %h", e_laddr[13:0], e_ldata[7:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
